// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core
// load/store port and an auxiliary port (loader/debug/DMA).
// One access in flight at a time: IDLE (grant) -> ACCESS (strobe)
// -> RWAIT (read latency) -> IDLE (rvalid pulse, may grant again).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   core_*/aux_*         req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_*                memory strobes, address, write/read data
//   busy, owner          not IDLE; requester in flight / last served
// Option: define DMEM_ARB_CORE_PRIORITY_EN for fixed core priority
// on simultaneous requests (default is round-robin).
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_q;
    logic              core_rvalid_q, aux_rvalid_q;
    logic [DATA_W-1:0] core_rdata_q, aux_rdata_q;
    logic              grant;
    logic              win_aux;
    logic              rd_done;

    // Winner select: a lone requester wins; on a tie the requester
    // that was not served last wins (owner resets to aux so core
    // takes the first tie).
    always_comb begin
        grant = (state_q == IDLE) && !reset && (core_req || aux_req);
`ifdef DMEM_ARB_CORE_PRIORITY_EN
        win_aux = !core_req;
`else
        win_aux = (core_req && aux_req) ? !owner_q : aux_req;
`endif
    end

    assign rd_done = (state_q == RWAIT) && (cnt_q == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RWAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            RWAIT: begin
                if (cnt_q == 2'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_gnt    = grant && !win_aux;
        aux_gnt     = grant && win_aux;
        mem_wr      = (state_q == ACCESS) && we_q;
        mem_rd      = (state_q == ACCESS) && !we_q;
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        busy        = (state_q != IDLE);
        owner       = owner_q;
        core_rvalid = core_rvalid_q;
        aux_rvalid  = aux_rvalid_q;
        core_rdata  = core_rdata_q;
        aux_rdata   = aux_rdata_q;
    end

    // Payload latch, owner tracking and read-data return. A read that
    // is in flight when reset hits is dropped because rd_done is only
    // sampled when reset is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= 2'd0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            owner_q       <= 1'b1;
            core_rvalid_q <= 1'b0;
            aux_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            aux_rdata_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            core_rvalid_q <= rd_done && !owner_q;
            aux_rvalid_q  <= rd_done && owner_q;
            if (grant) begin
                owner_q <= win_aux;
                we_q    <= win_aux ? aux_we    : core_we;
                addr_q  <= win_aux ? aux_addr  : core_addr;
                wdata_q <= win_aux ? aux_wdata : core_wdata;
            end
            if (rd_done && !owner_q) core_rdata_q <= mem_rd_data;
            if (rd_done && owner_q)  aux_rdata_q  <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized checks of dmem_arbiter
// against a transaction-level model and a memory stub.
module tb_dmem_arbiter;

    localparam int DW     = 32;
    localparam int AW     = 9;
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, aux_req, aux_we;
    logic [AW-1:0] core_addr, aux_addr;
    logic [DW-1:0] core_wdata, aux_wdata;
    logic          core_gnt, core_rvalid, aux_gnt, aux_rvalid;
    logic [DW-1:0] core_rdata, aux_rdata;
    logic          mem_wr, mem_rd, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .aux_req(aux_req), .aux_we(aux_we),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
        .aux_rdata(aux_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .busy(busy), .owner(owner)
    );

    // Memory stub: fixed read latency, garbage when not reading.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wr_data;
        end
        rd_pipe[0] <= mem_rd ? ram[mem_addr] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[RD_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    // Transaction-level model
    int            cyc = 0;
    int            free_cyc = 0;
    bit            acc_v, acc_we;
    int            acc_cyc;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    bit            rv_v, rv_port;
    int            rv_cyc;
    logic [DW-1:0] rv_data;
    bit            own_m = 1'b1;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            g_core, g_aux;
    int            n_gnt = 0;
    bit            win_log [$];

    // Snapshots of the last sampled cycle for directed checks
    logic          s_core_gnt, s_aux_gnt, s_mem_wr, s_mem_rd, s_busy;
    logic          s_core_rv, s_aux_rv, s_owner;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_wdata, s_core_rd, s_aux_rd;

    task automatic step();
        bit exp_gnt, exp_win, strobe, ret;
        @(negedge clk);
        s_core_gnt = core_gnt;  s_aux_gnt = aux_gnt;
        s_mem_wr   = mem_wr;    s_mem_rd  = mem_rd;
        s_busy     = busy;      s_owner   = owner;
        s_core_rv  = core_rvalid; s_aux_rv = aux_rvalid;
        s_mem_addr = mem_addr;  s_wdata   = mem_wr_data;
        s_core_rd  = core_rdata; s_aux_rd = aux_rdata;
        g_core = 1'b0;
        g_aux  = 1'b0;
        check("dual_gnt", core_gnt & aux_gnt, 0);
        check("dual_strobe", mem_wr & mem_rd, 0);
        check("dual_rvalid", core_rvalid & aux_rvalid, 0);
        if (reset) begin
            free_cyc = cyc + 1;
            acc_v = 0;
            rv_v = 0;
            own_m = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
        end else begin
            exp_gnt = (cyc >= free_cyc) && (core_req || aux_req);
            if (core_req && !aux_req)      exp_win = 1'b0;
            else if (aux_req && !core_req) exp_win = 1'b1;
            else begin
`ifdef DMEM_ARB_CORE_PRIORITY_EN
                exp_win = 1'b0;
`else
                exp_win = ~own_m;
`endif
            end
            check("core_gnt", core_gnt, exp_gnt && !exp_win);
            check("aux_gnt", aux_gnt, exp_gnt && exp_win);
            check("busy", busy, cyc < free_cyc);
            strobe = acc_v && (cyc == acc_cyc + 1);
            check("mem_wr", mem_wr, strobe && acc_we);
            check("mem_rd", mem_rd, strobe && !acc_we);
            if (strobe) begin
                check("mem_addr", mem_addr, acc_addr);
                if (acc_we) check("mem_wr_data", mem_wr_data, acc_data);
            end
            ret = rv_v && (cyc == rv_cyc);
            if (ret) exp_rd[rv_port] = rv_data;
            check("core_rvalid", core_rvalid, ret && !rv_port);
            check("aux_rvalid", aux_rvalid, ret && rv_port);
            check("core_rdata", core_rdata, exp_rd[0]);
            check("aux_rdata", aux_rdata, exp_rd[1]);
            check("owner", owner, own_m);
            if (exp_gnt) begin
                n_gnt++;
                win_log.push_back(exp_win);
                g_core   = !exp_win;
                g_aux    = exp_win;
                own_m    = exp_win;
                acc_v    = 1;
                acc_cyc  = cyc;
                acc_we   = exp_win ? aux_we : core_we;
                acc_addr = exp_win ? aux_addr : core_addr;
                acc_data = exp_win ? aux_wdata : core_wdata;
                if (acc_we) begin
                    shadow[acc_addr] = acc_data;
                    free_cyc = cyc + 2;
                end else begin
                    rv_v     = 1;
                    rv_port  = exp_win;
                    rv_cyc   = cyc + 2 + RD_LAT;
                    rv_data  = shadow[acc_addr];
                    free_cyc = rv_cyc;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input bit r, input bit w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_aux(input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d;
    endtask

    int t0, t_rv, t_aux, budget, target;
    bit got_rv;

    initial begin
        set_core(0, 0, '0, '0);
        set_aux(0, 0, '0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_owner", s_owner, 1);
        check("rst_busy", s_busy, 0);
        check("rst_mem_addr", s_mem_addr, 0);
        check("rst_wdata", s_wdata, 0);

        // Core write, aux idle
        set_core(1, 1, 9'h005, 32'hDEADBEEF);
        step();
        check("wr_core_gnt", s_core_gnt, 1);
        set_core(0, 0, '0, '0);
        step();
        check("wr_mem_wr", s_mem_wr, 1);
        check("wr_mem_addr", s_mem_addr, 9'h005);
        check("wr_mem_data", s_wdata, 32'hDEADBEEF);
        step();
        check("wr_busy_c2", s_busy, 0);

        // Aux write then read of 0x1FF
        set_aux(1, 1, 9'h1FF, 32'h12345678);
        step();
        set_aux(0, 0, '0, '0);
        step();
        set_aux(1, 0, 9'h1FF, '0);
        step();
        check("rd_aux_gnt", s_aux_gnt, 1);
        set_aux(0, 0, '0, '0);
        step();
        check("rd_mem_rd", s_mem_rd, 1);
        repeat (RD_LAT) step();
        step();
        check("rd_aux_rvalid", s_aux_rv, 1);
        check("rd_aux_rdata", s_aux_rd, 32'h12345678);
        check("rd_core_rvalid", s_core_rv, 0);

        // Both requesters reading continuously
        win_log.delete();
        set_core(1, 0, 9'h005, '0);
        set_aux(1, 0, 9'h1FF, '0);
        budget = 0;
        while (win_log.size() < 8 && budget < 100) begin
            step();
            budget++;
            if (g_core) core_addr = AW'($urandom_range(0, 15));
            if (g_aux)  aux_addr  = AW'($urandom_range(0, 15));
        end
        check("rr_grants", win_log.size(), 8);
        for (int k = 0; k < 8 && k < win_log.size(); k++) begin
`ifdef DMEM_ARB_CORE_PRIORITY_EN
            check("prio_order", win_log[k], 0);
`else
            check("rr_order", win_log[k], k % 2);
`endif
        end
        set_core(0, 0, '0, '0);
        set_aux(0, 0, '0, '0);
        repeat (RD_LAT + 3) step();

        // Core read; aux request arrives during RWAIT
        set_core(1, 0, 9'h005, '0);
        step();
        t0 = cyc - 1;
        check("lat_core_gnt", s_core_gnt, 1);
        set_core(0, 0, '0, '0);
        step();
        step();
        set_aux(1, 0, 9'h1FF, '0);
        got_rv = 0;
        t_rv = -1;
        t_aux = -1;
        budget = 0;
        while (t_aux < 0 && budget < 20) begin
            step();
            budget++;
            if (s_core_rv && !got_rv) begin got_rv = 1; t_rv = cyc - 1; end
            if (s_aux_gnt) begin t_aux = cyc - 1; set_aux(0, 0, '0, '0); end
        end
        check("lat_rvalid", t_rv - t0, 2 + RD_LAT);
        check("lat_aux_gnt_cyc", t_aux, t_rv);
        repeat (RD_LAT + 3) step();

        // Reset during RWAIT of an aux read
        set_aux(1, 0, 9'h1FF, '0);
        step();
        check("rst_aux_gnt", s_aux_gnt, 1);
        set_aux(0, 0, '0, '0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_core(1, 0, 9'h005, '0);
        set_aux(1, 0, 9'h1FF, '0);
        step();
        check("post_rst_core_gnt", s_core_gnt, 1);
        check("post_rst_aux_rv", s_aux_rv, 0);
        check("post_rst_aux_rd", s_aux_rd, 0);
        check("post_rst_mem_addr", s_mem_addr, 0);
        set_core(0, 0, '0, '0);
        set_aux(0, 0, '0, '0);
        repeat (RD_LAT + 4) step();

        // Randomized mix
        target = n_gnt + 1000;
        budget = 0;
        while (n_gnt < target && budget < 20000) begin
            if (!core_req && $urandom_range(0, 1) == 0)
                set_core(1, 1'($urandom), AW'($urandom_range(0, 15)),
                         $urandom);
            if (!aux_req && $urandom_range(0, 1) == 0)
                set_aux(1, 1'($urandom), AW'($urandom_range(0, 15)),
                        $urandom);
            step();
            budget++;
            if (g_core) set_core(0, 0, '0, '0);
            if (g_aux)  set_aux(0, 0, '0, '0);
        end
        check("rand_done", n_gnt >= target, 1);
        set_core(0, 0, '0, '0);
        set_aux(0, 0, '0, '0);
        repeat (RD_LAT + 4) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (9-bit word address, 32-bit data) used by the RISC-V core.
- Shares the memory between the core load/store port ("core") and an auxiliary port ("aux": program loader / debug / DMA).
- Handles one access at a time: request/grant handshake, memory strobe, and read-data return after a fixed memory latency.

Parameters:
- DATA_W, 32, data width of memory and both requesters
- ADDR_W, 9, memory address width
- RD_LAT, 1, memory read latency in cycles from rd strobe to valid mem_rd_data; legal range 1..4

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- core_req  input  1  core access request; held with payload until core_gnt
- core_we  input  1  1 = write, 0 = read
- core_addr  input  ADDR_W  core address
- core_wdata  input  DATA_W  core write data
- core_gnt  output  1  request accepted, payload captured this cycle
- core_rvalid  output  1  one-cycle pulse, core_rdata valid
- core_rdata  output  DATA_W  read data to core
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same as core_* for aux
- mem_wr  output  1  memory write strobe
- mem_rd  output  1  memory read strobe
- mem_addr  output  ADDR_W  memory address
- mem_wr_data  output  DATA_W  memory write data
- mem_rd_data  input  DATA_W  memory read data
- busy  output  1  state != IDLE
- owner  output  1  0 = core, 1 = aux; requester of the access in flight or last served

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; all gnt/rvalid/mem_wr/mem_rd/busy = 0
  - rdata registers, latched addr/wdata = 0; owner = 1 (aux), so core wins the first tie
  - A read in flight is discarded; no rvalid is ever issued for it.
- FSM states: IDLE, ACCESS, RWAIT.
- IDLE:
  - No req: stay.
  - Any req: select winner. Single requester wins. If both request, round-robin: winner = !owner.
  - gnt[winner] asserted combinationally this cycle; latch we/addr/wdata; owner <= winner; next ACCESS.
  - Loser's gnt stays 0; it must hold req and payload.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wr_data driven from latches; mem_wr = latched we, mem_rd = !latched we.
  - Write: next IDLE.
  - Read: load counter = RD_LAT-1; next RWAIT.
- RWAIT:
  - Counter 0: capture mem_rd_data into owner's rdata register and pulse owner's rvalid next cycle, concurrently with the return to IDLE.
  - Otherwise decrement.
  - The IDLE cycle carrying rvalid may also grant a new request.
- mem_wr/mem_rd are 0 outside ACCESS; mem_addr/mem_wr_data hold their latched values.
- Requests are sampled only in IDLE; req in other states is ignored (no queueing). A requester must deassert req (or present a new payload) the cycle after gnt.
- rdata holds its value until that requester's next read completes.
- Timing:
  - Write occupancy: 2 cycles from req to IDLE.
  - Read: gnt at cycle 0, mem_rd at cycle 1, rvalid at cycle 2+RD_LAT.
- Never assert both gnts, both rvalids, or mem_wr and mem_rd together.

Optional Feature:
- DMEM_ARB_CORE_PRIORITY_EN defined: fixed priority; on simultaneous req, core always wins. Aux is served only when core_req = 0 in IDLE. owner is still updated.
- Undefined: round-robin as above.

Test Plan:
- Core write addr=0x05 data=0xDEADBEEF, aux idle -> core_gnt in cycle 0; mem_wr=1, mem_addr=0x05, mem_wr_data=0xDEADBEEF in cycle 1; busy=0 in cycle 2.
- Aux read addr=0x1FF, memory returns 0x12345678, RD_LAT=1 -> mem_rd in cycle 1; aux_rvalid=1, aux_rdata=0x12345678 in cycle 3; core_rvalid stays 0.
- Both requesters continuously request reads after reset -> grants alternate core, aux, core, aux. With DMEM_ARB_CORE_PRIORITY_EN, only core is granted while core_req=1.
- RD_LAT=3, core read -> rvalid exactly 5 cycles after gnt. A second request arriving during RWAIT gets no gnt until IDLE, and is granted in the same cycle as the first rvalid.
- reset asserted in the RWAIT cycle of an aux read -> next cycle all outputs 0, state IDLE, no aux_rvalid ever for that read. The first core request after release is granted.
- Randomized core/aux mix of 1000 accesses against a memory model -> every read returns the last written value. Assertions hold: no dual gnt, no dual strobe.
